picomips_sequencer: RTL and testbench

- Instruction fetch/decode/sequence controller for the picoMIPS 8-bit datapath.
- Fetches from a synchronous-read program ROM and decodes each word into the datapath controls: ALU function, immediate select, switch select, destination and source operands, register write enable.
- Sequences control flow: jump, branch-on-zero, wait-for-button handshake and halt.
- Sits between program ROM and datapath in the CPU top level.

---
 rtl/picomips_sequencer.sv | 121 ++++++++++++
 tb/tb_picomips_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picomips_sequencer.sv
// picoMIPS fetch/decode/sequence controller: 3-cycle FETCH/DECODE/EXEC loop with WAIT and HALT.
// Define PICOMIPS_SEQ_CALL_EN to add CALL/RET through a one-entry link register.
module picomips_sequencer #(
    parameter  int N      = 8,
    parameter  int A_SIZE = 3,
    parameter  int R_SIZE = 3,
    parameter  int P_SIZE = 8,
    localparam int I_SIZE = 5 + R_SIZE + N
) (
    input  logic              clk,
    input  logic              nReset,
    output logic [P_SIZE-1:0] progAddr,
    input  logic [I_SIZE-1:0] instrIn,
    input  logic [N-1:0]      aluResult,
    input  logic              go,
    output logic [A_SIZE-1:0] aluFunc,
    output logic              aluImmediate,
    output logic              immSwitches,
    output logic [R_SIZE-1:0] opD,
    output logic [N-1:0]      opS,
    output logic              regWe,
    output logic              waiting,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t            state_q;
    logic [P_SIZE-1:0] pc_q;
    logic [I_SIZE-1:0] ir_q;
    logic              z_q;
    logic [2:0]        go_q;
`ifdef PICOMIPS_SEQ_CALL_EN
    logic [P_SIZE-1:0] lr_q;
`endif

    logic [4:0]        op;
    logic [N-1:0]      imm;
    logic              is_alu;
    logic              go_edge;
    logic [P_SIZE-1:0] pc_inc;
    logic [P_SIZE-1:0] target;

    assign op      = ir_q[I_SIZE-1 -: 5];
    assign imm     = ir_q[N-1:0];
    assign is_alu  = (op[4:3] != 2'b00);
    assign pc_inc  = pc_q + P_SIZE'(1);
    assign target  = imm[P_SIZE-1:0];
    // go_q[1] is the synchronised button, go_q[2] its previous value
    assign go_edge = go_q[1] & ~go_q[2];

    assign progAddr     = pc_q;
    assign aluFunc      = is_alu ? op[2:0] : '0;
    assign aluImmediate = op[4];
    assign immSwitches  = op[4] & op[3];
    assign opD          = ir_q[N +: R_SIZE];
    assign opS          = imm;
    assign regWe        = (state_q == S_EXEC) && is_alu;
    assign waiting      = (state_q == S_WAIT);
    assign halted       = (state_q == S_HALT);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            go_q    <= '0;
`ifdef PICOMIPS_SEQ_CALL_EN
            lr_q    <= '0;
`endif
        end else begin
            go_q <= {go_q[1:0], go};
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    ir_q    <= instrIn;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    state_q <= S_FETCH;
                    if (is_alu) begin
                        z_q  <= (aluResult == '0);
                        pc_q <= pc_inc;
                    end else begin
                        case (op[2:0])
                            3'b001: pc_q <= target;
                            3'b010: pc_q <= z_q ? target : pc_inc;
                            3'b011: state_q <= S_WAIT;
                            3'b100: state_q <= S_HALT;
`ifdef PICOMIPS_SEQ_CALL_EN
                            3'b101: begin
                                lr_q <= pc_inc;
                                pc_q <= target;
                            end
                            3'b110: pc_q <= lr_q;
`endif
                            default: pc_q <= pc_inc;
                        endcase
                    end
                end
                // edges arriving outside WAIT are simply never looked at
                S_WAIT: begin
                    if (go_edge) begin
                        pc_q    <= pc_inc;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_picomips_sequencer.sv
// Self-checking bench for picomips_sequencer: bench-side ROM model plus queues of expected
// fetch addresses and decode fields, compared as the sequencer reaches each stage.
module tb_picomips_sequencer;

    logic        clk;
    logic        nReset;
    logic [7:0]  progAddr;
    logic [15:0] instrIn;
    logic [7:0]  aluResult;
    logic        go;
    logic [2:0]  aluFunc;
    logic        aluImmediate;
    logic        immSwitches;
    logic [2:0]  opD;
    logic [7:0]  opS;
    logic        regWe;
    logic        waiting;
    logic        halted;

    typedef struct packed {
        logic [2:0] func;
        logic       imm;
        logic       sw;
        logic [2:0] d;
        logic [7:0] s;
        logic       we;
    } dec_t;

    logic [15:0] rom [256];
    logic [7:0]  exp_q[$];
    dec_t        dec_q[$];
    int          checks = 0;
    int          errors = 0;

    picomips_sequencer dut (
        .clk(clk), .nReset(nReset), .progAddr(progAddr), .instrIn(instrIn),
        .aluResult(aluResult), .go(go), .aluFunc(aluFunc), .aluImmediate(aluImmediate),
        .immSwitches(immSwitches), .opD(opD), .opS(opS), .regWe(regWe),
        .waiting(waiting), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read program ROM
    always @(posedge clk) instrIn <= rom[progAddr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, time limit expired");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    // leaves the bench at a negedge with the DUT in FETCH of address 0
    task automatic do_reset();
        @(negedge clk);
        nReset = 1'b0;
        cyc(2);
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = 16'h9105;
        aluResult = 8'h11;
        go = 1'b0;
        do_reset();
        cyc(2);
        checks++;
        if (regWe !== 1'b1) begin
            errors++; $display("FAIL reset_pre_exec: regWe=%b expected 1", regWe);
        end
        #2 nReset = 1'b0;
        #1;
        checks++;
        if ({progAddr, aluFunc, aluImmediate, immSwitches, opD, opS, regWe, waiting, halted} !== '0) begin
            errors++;
            $display("FAIL reset_async_outputs: pa=%h f=%h ai=%b sw=%b d=%h s=%h we=%b w=%b h=%b expected all 0",
                     progAddr, aluFunc, aluImmediate, immSwitches, opD, opS, regWe, waiting, halted);
        end
        @(negedge clk);
        nReset = 1'b1;
        checks++;
        if (progAddr !== 8'h00 || regWe !== 1'b0) begin
            errors++; $display("FAIL reset_release: progAddr=%h regWe=%b expected 00/0", progAddr, regWe);
        end
        cyc(1);
        checks++;
        if (regWe !== 1'b0) begin
            errors++; $display("FAIL reset_cycle2: regWe=%b expected 0", regWe);
        end
        cyc(1);
        checks++;
        if (regWe !== 1'b1 || opS !== 8'h05) begin
            errors++; $display("FAIL reset_first_exec: regWe=%b opS=%h expected 1/05", regWe, opS);
        end
    endtask

    task automatic test_alu_decode();
        dec_t e;
        clear_rom();
        rom[0] = 16'h9105;
        rom[1] = 16'h4A12;
        rom[2] = 16'hFBAA;
        rom[3] = 16'h0533;
        dec_q.push_back('{3'd2, 1'b1, 1'b0, 3'd1, 8'h05, 1'b1});
        dec_q.push_back('{3'd1, 1'b0, 1'b0, 3'd2, 8'h12, 1'b1});
        dec_q.push_back('{3'd7, 1'b1, 1'b1, 3'd3, 8'hAA, 1'b1});
        dec_q.push_back('{3'd0, 1'b0, 1'b0, 3'd5, 8'h33, 1'b0});
        aluResult = 8'h01;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (progAddr !== 8'(i) || regWe !== 1'b0) begin
                errors++; $display("FAIL alu_fetch[%0d]: progAddr=%h regWe=%b expected %h/0", i, progAddr, regWe, i);
            end
            cyc(1);
            checks++;
            if (regWe !== 1'b0) begin
                errors++; $display("FAIL alu_decode_we[%0d]: regWe=%b expected 0", i, regWe);
            end
            cyc(1);
            e = dec_q.pop_front();
            checks++;
            if ({aluFunc, aluImmediate, immSwitches, opD, opS, regWe} !== e) begin
                errors++;
                $display("FAIL alu_exec[%0d]: got f=%h ai=%b sw=%b d=%h s=%h we=%b expected f=%h ai=%b sw=%b d=%h s=%h we=%b",
                         i, aluFunc, aluImmediate, immSwitches, opD, opS, regWe,
                         e.func, e.imm, e.sw, e.d, e.s, e.we);
            end
            cyc(1);
        end
        checks++;
        if (progAddr !== 8'h04 || regWe !== 1'b0) begin
            errors++; $display("FAIL alu_after: progAddr=%h regWe=%b expected 04/0", progAddr, regWe);
        end
    endtask

    task automatic test_branch();
        logic [7:0] e;
        for (int taken = 1; taken >= 0; taken--) begin
            clear_rom();
            rom[0] = 16'h4100;
            rom[1] = 16'h1006;
            rom[6] = 16'h1009;
            if (taken != 0) begin
                exp_q.push_back(8'h00); exp_q.push_back(8'h01);
                exp_q.push_back(8'h06); exp_q.push_back(8'h09);
            end else begin
                exp_q.push_back(8'h00); exp_q.push_back(8'h01);
                exp_q.push_back(8'h02); exp_q.push_back(8'h03);
            end
            aluResult = (taken != 0) ? 8'h00 : 8'h03;
            do_reset();
            for (int i = 0; i < 4; i++) begin
                // nonzero result after the ALU op: control ops must not refresh Z
                if (i == 1) aluResult = 8'h03;
                e = exp_q.pop_front();
                checks++;
                if (progAddr !== e) begin
                    errors++; $display("FAIL bz_taken%0d[%0d]: progAddr=%h expected %h", taken, i, progAddr, e);
                end
                cyc(3);
            end
        end
    endtask

    task automatic test_wait();
        logic [7:0] e;
        int bad;
        int k;
        clear_rom();
        rom[0] = 16'h1800;
        rom[1] = 16'h1800;
        go = 1'b0;
        do_reset();
        cyc(3);
        checks++;
        if (waiting !== 1'b1 || progAddr !== 8'h00) begin
            errors++; $display("FAIL wait_enter: waiting=%b progAddr=%h expected 1/00", waiting, progAddr);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (waiting !== 1'b1 || progAddr !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wait_hold: %0d bad cycles expected 0", bad);
        end
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        go = 1'b1;
        k = 0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            k = i;
            if (waiting === 1'b0) break;
        end
        e = exp_q.pop_front();
        checks++;
        if (waiting !== 1'b0 || k > 3 || progAddr !== e) begin
            errors++; $display("FAIL wait_release: waiting=%b cycles=%0d progAddr=%h expected 0/<=3/%h", waiting, k, progAddr, e);
        end
        cyc(3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (waiting !== 1'b1 || progAddr !== 8'h01) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wait_single_advance: %0d bad cycles expected 0", bad);
        end
        go = 1'b0;
        cyc(3);
        go = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            if (waiting === 1'b0) break;
        end
        e = exp_q.pop_front();
        checks++;
        if (waiting !== 1'b0 || progAddr !== e) begin
            errors++; $display("FAIL wait_second: waiting=%b progAddr=%h expected 0/%h", waiting, progAddr, e);
        end
        go = 1'b0;
    endtask

    task automatic test_go_ignored();
        int bad;
        clear_rom();
        rom[1] = 16'h1800;
        go = 1'b0;
        do_reset();
        go = 1'b1;
        cyc(1);
        go = 1'b0;
        cyc(5);
        checks++;
        if (waiting !== 1'b1 || progAddr !== 8'h01) begin
            errors++; $display("FAIL go_ignored_enter: waiting=%b progAddr=%h expected 1/01", waiting, progAddr);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (waiting !== 1'b1 || progAddr !== 8'h01) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL go_ignored_hold: %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_jmp_wrap();
        logic [7:0] e;
        clear_rom();
        rom[0] = 16'h0803;
        rom[3] = 16'h08FF;
        exp_q.push_back(8'h00); exp_q.push_back(8'h03); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h03);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (progAddr !== e) begin
                errors++; $display("FAIL jmp_wrap[%0d]: progAddr=%h expected %h", i, progAddr, e);
            end
            cyc(3);
        end
    endtask

    task automatic test_halt();
        logic [7:0] e;
        int bad;
        clear_rom();
        rom[0] = 16'h0803;
        rom[3] = 16'h2000;
        rom[4] = 16'h9105;
        go = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'h03);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (progAddr !== e) begin
                errors++; $display("FAIL halt_seq[%0d]: progAddr=%h expected %h", i, progAddr, e);
            end
            cyc(3);
        end
        checks++;
        if (halted !== 1'b1 || waiting !== 1'b0 || progAddr !== 8'h03) begin
            errors++; $display("FAIL halt_enter: halted=%b waiting=%b progAddr=%h expected 1/0/03", halted, waiting, progAddr);
        end
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            go = (i % 6) < 3;
            cyc(1);
            if (halted !== 1'b1 || progAddr !== 8'h03 || regWe !== 1'b0) bad++;
        end
        go = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL halt_frozen: %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_call_ret();
        logic [7:0] e;
        int n;
        clear_rom();
        rom[2] = 16'h2808;
        rom[8] = 16'h3000;
        rom[4] = 16'h2000;
        exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
`ifdef PICOMIPS_SEQ_CALL_EN
        exp_q.push_back(8'h08); exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        n = 6;
`else
        exp_q.push_back(8'h03); exp_q.push_back(8'h04);
        n = 5;
`endif
        do_reset();
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (progAddr !== e) begin
                errors++; $display("FAIL call_ret[%0d]: progAddr=%h expected %h", i, progAddr, e);
            end
            cyc(3);
        end
    endtask

    initial begin
        nReset = 1'b0;
        go = 1'b0;
        aluResult = 8'h00;
        clear_rom();
        test_reset();
        test_alu_decode();
        test_branch();
        test_wait();
        test_go_ignored();
        test_jmp_wrap();
        test_halt();
        test_call_ret();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
